// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Purpose:
//   Drives all eight 3-bit vectors {X,Y,Z} = 0..7 into a downstream 3-input
//   gate circuit. Each vector is held for DWELL cycles. The circuit output F is
//   sampled on the last cycle of each vector to build an 8-bit truth table. The
//   captured table is then compared against the golden table EXPECT.
//
// Parameters:
//   DWELL     clock cycles each vector is held (2..255)
//   EXPECT    golden truth table, bit i = F for {X,Y,Z} = i
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   request one full scan (sampled in IDLE only)
//   abort      in   cancel a scan in progress
//   F          in   output of the gate circuit under test
//   X, Y, Z    out  vector bits 2, 1, 0 driven to the gate circuit
//   busy       out  high while scanning
//   done       out  one-cycle completion pulse
//   table_out  out  captured truth table
//   pass       out  table_out == EXPECT, held until the next start
//   fail_idx   out  lowest vector index that mismatched (0 when pass)
// -----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int         DWELL  = 20,
    parameter logic [7:0] EXPECT = 8'h8C
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       F,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [2:0] fail_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set_idx(input logic [7:0] vec);
        logic [2:0] result;
        result = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                result = 3'(i);
            end
        end
        return result;
    endfunction

    state_t     state_r, state_s;
    logic [2:0] idx_r, idx_s;
    logic [7:0] cnt_r, cnt_s;
    logic [2:0] xyz_r, xyz_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic [7:0] table_r, table_s;
    logic       pass_r, pass_s;
    logic [2:0] fail_r, fail_s;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
            cnt_r   <= 8'd0;
            xyz_r   <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            table_r <= 8'h00;
            pass_r  <= 1'b0;
            fail_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            xyz_r   <= xyz_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            table_r <= table_s;
            pass_r  <= pass_s;
            fail_r  <= fail_s;
        end
    end

    // Next-state and next-output logic. The outputs are computed one cycle
    // ahead so that every port comes straight from a register.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        xyz_s   = 3'd0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        table_s = table_r;
        pass_s  = pass_r;
        fail_s  = fail_r;

        case (state_r)
            ST_IDLE: begin
                // abort takes priority over start
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    state_s = ST_RUN;
                    idx_s   = 3'd0;
                    cnt_s   = 8'd0;
                    busy_s  = 1'b1;
                    xyz_s   = 3'd0;
                    table_s = 8'h00;
                    pass_s  = 1'b0;
                    fail_s  = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Partial capture is kept; the final sample is dropped
                    // when abort coincides with it.
                    state_s = ST_IDLE;
                    idx_s   = 3'd0;
                    cnt_s   = 8'd0;
                    pass_s  = 1'b0;
                end else if (cnt_r == LAST_CNT) begin
                    table_s[idx_r] = F;
                    cnt_s          = 8'd0;
                    if (idx_r == 3'd7) begin
                        state_s = ST_DONE;
                        idx_s   = 3'd0;
                    end else begin
                        idx_s  = idx_r + 3'd1;
                        busy_s = 1'b1;
                        xyz_s  = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s  = cnt_r + 8'd1;
                    busy_s = 1'b1;
                    xyz_s  = idx_r;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
                if (abort) begin
                    pass_s = 1'b0;
                end else begin
                    done_s = 1'b1;
                    pass_s = (table_r == EXPECT);
                    fail_s = lowest_set_idx(table_r ^ EXPECT);
                end
            end

            default: begin
                state_s = ST_IDLE;
                idx_s   = 3'd0;
                cnt_s   = 8'd0;
            end
        endcase
    end

    assign X         = xyz_r[2];
    assign Y         = xyz_r[1];
    assign Z         = xyz_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign table_out = table_r;
    assign pass      = pass_r;
    assign fail_idx  = fail_r;

endmodule

// File: tb/tb_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// tb_truth_table_scanner
//
// Purpose:
//   Directed self-checking bench for truth_table_scanner with DWELL = 4 and
//   EXPECT = 8'h8C. A selectable gate model drives F from X, Y, Z.
// -----------------------------------------------------------------------------
module tb_truth_table_scanner;

    localparam int         DWELL  = 4;
    localparam logic [7:0] EXPECT = 8'h8C;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       F;
    logic       X, Y, Z;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       pass;
    logic [2:0] fail_idx;

    int         mode;
    int         checks_cnt;
    int         errors_cnt;

    truth_table_scanner #(
        .DWELL  (DWELL),
        .EXPECT (EXPECT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .F         (F),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .pass      (pass),
        .fail_idx  (fail_idx)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gate circuit under test: 0 correct, 1 stuck-at-0, 2 AND3, 3 NOT X.
    always_comb begin
        case (mode)
            0:       F = (Y & ~X) | (Y & Z);
            1:       F = 1'b0;
            2:       F = X & Y & Z;
            3:       F = ~X;
            default: F = 1'b0;
        endcase
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follow a scan from just after its accept edge up to just after the done
    // pulse appears. If pulse_start is set, start toggles during RUN.
    task automatic follow_scan(input logic [7:0] et, input logic ep, input logic [2:0] ef,
                               input bit pulse_start);
        for (int k = 0; k < 8 * DWELL; k++) begin
            check_value("xyz", {29'd0, X, Y, Z}, k / DWELL);
            check_value("busy_run", {31'd0, busy}, 32'd1);
            check_value("done_run", {31'd0, done}, 32'd0);
            if (pulse_start) start = (k % 2 == 0);
            step();
        end
        if (pulse_start) start = 1'b0;
        check_value("busy_donest", {31'd0, busy}, 32'd0);
        check_value("done_early", {31'd0, done}, 32'd0);
        step();
        check_value("done_pulse", {31'd0, done}, 32'd1);
        check_value("table", {24'd0, table_out}, {24'd0, et});
        check_value("pass", {31'd0, pass}, {31'd0, ep});
        check_value("fail_idx", {29'd0, fail_idx}, {29'd0, ef});
    endtask

    task automatic start_scan(input int m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic full_scan(input int m, input logic [7:0] et, input logic ep, input logic [2:0] ef);
        start_scan(m);
        follow_scan(et, ep, ef, 1'b0);
        step();
        check_value("done_one_cycle", {31'd0, done}, 32'd0);
        check_value("pass_held", {31'd0, pass}, {31'd0, ep});
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        mode       = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        step();
        step();
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_done", {31'd0, done}, 32'd0);
        check_value("rst_table", {24'd0, table_out}, 32'd0);
        check_value("rst_pass", {31'd0, pass}, 32'd0);
        check_value("rst_fail", {29'd0, fail_idx}, 32'd0);
        check_value("rst_xyz", {29'd0, X, Y, Z}, 32'd0);

        // Start on the first edge with rst_n released.
        rst_n = 1'b1;
        start_scan(0);
        check_value("first_accept", {31'd0, busy}, 32'd1);
        follow_scan(8'h8C, 1'b1, 3'd0, 1'b0);
        step();
        check_value("pass_held0", {31'd0, pass}, 32'd1);

        // Faulty circuits.
        full_scan(1, 8'h00, 1'b0, 3'd2);
        full_scan(2, 8'h80, 1'b0, 3'd2);
        full_scan(3, 8'h0F, 1'b0, 3'd0);

        // Start pulses during RUN have no effect.
        start_scan(0);
        follow_scan(8'h8C, 1'b1, 3'd0, 1'b1);
        step();

        // abort and start together in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check_value("abort_idle_busy", {31'd0, busy}, 32'd0);
        check_value("abort_idle_pass", {31'd0, pass}, 32'd1);

        // Abort while idx = 3.
        start_scan(0);
        for (int k = 0; k < 13; k++) step();
        check_value("pre_abort_xyz", {29'd0, X, Y, Z}, 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_value("abort_busy", {31'd0, busy}, 32'd0);
        check_value("abort_xyz", {29'd0, X, Y, Z}, 32'd0);
        check_value("abort_pass", {31'd0, pass}, 32'd0);
        check_value("abort_table", {24'd0, table_out}, 32'h04);
        for (int k = 0; k < 40; k++) begin
            check_value("abort_no_done", {31'd0, done}, 32'd0);
            step();
        end

        // Abort on the final sample: no done, last bit not captured.
        start_scan(0);
        for (int k = 0; k < 8 * DWELL - 1; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_value("abort_last_busy", {31'd0, busy}, 32'd0);
        check_value("abort_last_table", {24'd0, table_out}, 32'h0C);
        step();
        check_value("abort_last_done", {31'd0, done}, 32'd0);
        step();
        check_value("abort_last_done2", {31'd0, done}, 32'd0);

        // Abort in DONE state: no done pulse.
        start_scan(0);
        for (int k = 0; k < 8 * DWELL; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_value("abort_done_done", {31'd0, done}, 32'd0);
        check_value("abort_done_pass", {31'd0, pass}, 32'd0);
        check_value("abort_done_table", {24'd0, table_out}, 32'h8C);

        // start held through two scans.
        mode  = 0;
        start = 1'b1;
        step();
        follow_scan(8'h8C, 1'b1, 3'd0, 1'b0);
        check_value("held_idle_busy", {31'd0, busy}, 32'd0);
        step();
        check_value("held_restart_busy", {31'd0, busy}, 32'd1);
        check_value("held_restart_done", {31'd0, done}, 32'd0);
        check_value("held_restart_table", {24'd0, table_out}, 32'h00);
        check_value("held_restart_pass", {31'd0, pass}, 32'd0);
        follow_scan(8'h8C, 1'b1, 3'd0, 1'b0);
        start = 1'b0;
        step();

        // Reset at idx = 5 with start asserted alongside.
        start_scan(0);
        for (int k = 0; k < 21; k++) step();
        check_value("pre_rst_xyz", {29'd0, X, Y, Z}, 32'd5);
        rst_n = 1'b0;
        start = 1'b1;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        check_value("mrst_busy", {31'd0, busy}, 32'd0);
        check_value("mrst_xyz", {29'd0, X, Y, Z}, 32'd0);
        check_value("mrst_table", {24'd0, table_out}, 32'd0);
        check_value("mrst_pass", {31'd0, pass}, 32'd0);
        check_value("mrst_fail", {29'd0, fail_idx}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            check_value("mrst_no_done", {31'd0, done}, 32'd0);
            check_value("mrst_idle", {31'd0, busy}, 32'd0);
            step();
        end
        full_scan(0, 8'h8C, 1'b1, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
